// File: rtl/imem_loader_pkg.sv
// loader_pkg: shared types and constants for the instruction memory loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} loader_state_t;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and memory word-write port of the loader
interface imem_loader_if #(parameter int ADDR_W = 32);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  modport slave (input in_valid, in_data, output in_ready, we, waddr, wdata);
  modport master (output in_valid, in_data, input in_ready, we, waddr, wdata);
endinterface

// File: rtl/imem_loader_le_word_packer.sv
// le_word_packer: packs bytes into a little-endian 32-bit word, lowest lane first
module le_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last
);
  logic [1:0]  lane;
  logic [31:0] r;
  assign last = push && lane == 2'd3;
  // word includes the byte being pushed so a full word is visible on the 4th push
  always_comb begin
    word = r;
    if (push) word[{lane, 3'b000} +: 8] = din;
  end
  // lane counter and word register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lane <= '0;
      r    <= '0;
    end else if (clr) begin
      lane <= '0;
      r    <= '0;
    end else if (push) begin
      lane <= lane + 2'd1;
      r    <= word;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a framed byte stream into instruction memory as 32-bit words
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int DEPTH = MEM_BYTES / BYTES_PER_WORD;
  localparam int CW    = $clog2(DEPTH + 1);
  loader_state_t state, nxt;
  logic [CW-1:0] n, word_idx;
  logic [31:0]   word;
  logic          xfer, push, last, hdr_ok;
  assign bus.in_ready = (state == HDR || state == DATA) && !abort;
  assign xfer   = bus.in_valid && bus.in_ready;
  assign push   = xfer && state == DATA;
  assign hdr_ok = bus.in_data != 8'd0 && 32'(bus.in_data) <= DEPTH;
  assign busy   = state inside {HDR, DATA, WRITE, DONE};
  le_word_packer u_packer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!(state == DATA || state == WRITE)),
    .push (push),
    .din  (bus.in_data),
    .word (word),
    .last (last)
  );
  // next-state decode; abort and held in_valid gaps fall out of the ternaries
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? HDR : IDLE;
      HDR:     nxt = abort ? IDLE : xfer ? (hdr_ok ? DATA : ERR) : HDR;
      DATA:    nxt = abort ? IDLE : last ? WRITE : DATA;
      WRITE:   nxt = abort ? IDLE : word_idx == n - 1'b1 ? DONE : DATA;
      default: nxt = IDLE;
    endcase
  end
  // state, counters and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      n         <= '0;
      word_idx  <= '0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state  <= nxt;
      bus.we <= nxt == WRITE;
      done   <= nxt == DONE;
      if (nxt == WRITE) begin
        bus.waddr <= ADDR_W'({word_idx, 2'b00});
        bus.wdata <= word;
      end
      if (state == HDR && xfer && hdr_ok) begin
        n        <= CW'(bus.in_data);
        word_idx <= '0;
      end
      if (state == WRITE && nxt == DATA) word_idx <= word_idx + 1'b1;
      if (state == IDLE && start) err <= 1'b0;
      else if (nxt == ERR) err <= 1'b1;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader
module tb_imem_loader;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic busy, done, err;
  int passed = 0, total = 0, done_cnt = 0;
  logic [63:0] sb[$];
  imem_loader_if #(.ADDR_W(32)) bif ();
  imem_loader #(.ADDR_W(32), .MEM_BYTES(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .bus(bif), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bif.we) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("waddr", bif.waddr, e[63:32]);
        chk("wdata", bif.wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int k;
    if (gaps) repeat ($urandom_range(0, 3)) tick();
    bif.in_valid = 1; bif.in_data = b;
    k = 0;
    @(negedge clk);
    while (!bif.in_ready && k < 200) begin @(negedge clk); k++; end
    if (!bif.in_ready) chk("rdy_timeout", 32'(bif.in_ready), 1);
    tick();
    bif.in_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send(w[i*8 +: 8], gaps);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && !done; k++) @(negedge clk);
    chk("done_seen", 32'(done), 1);
    chk("sb_empty", 32'(sb.size()), 0);
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, 32'(bif.we), 0);
    chk({tag, "_waddr"}, bif.waddr, 0);
    chk({tag, "_wdata"}, bif.wdata, 0);
    chk({tag, "_rdy"}, 32'(bif.in_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    int d0;
    logic [31:0] w;
    bif.in_valid = 0; bif.in_data = 0;
    #12 chk_zero("rst");
    tick(); rst_n = 1; tick();

    pulse_start();
    sb.push_back({32'h0, 32'h00500113});
    send(8'h01, 0); send_word(32'h00500113, 0);
    @(negedge clk); chk("t1_we", 32'(bif.we), 1);
    @(negedge clk); chk("t1_done", 32'(done), 1); chk("t1_busy_done", 32'(busy), 1); chk("t1_we_low", 32'(bif.we), 0);
    @(negedge clk); chk("t1_busy_low", 32'(busy), 0); chk("t1_done_low", 32'(done), 0);
    tick();

    pulse_start();
    sb.push_back({32'h0, 32'h00C00193});
    sb.push_back({32'h4, 32'hFF718393});
    send(8'h02, 1); send_word(32'h00C00193, 1); send_word(32'hFF718393, 1);
    wait_done();

    pulse_start(); send(8'h00, 0);
    chk("t3_err0", 32'(err), 1); chk("t3_busy0", 32'(busy), 0);
    tick(); chk("t3_err_sticky", 32'(err), 1); chk("t3_rdy_idle", 32'(bif.in_ready), 0);
    pulse_start(); chk("t3_err_clr", 32'(err), 0);
    send(8'h21, 0); chk("t3_err21", 32'(err), 1);
    tick(); pulse_start(); chk("t3_err_clr2", 32'(err), 0);
    sb.push_back({32'h0, 32'hDEADBEEF});
    send(8'h01, 0); send_word(32'hDEADBEEF, 0);
    wait_done(); chk("t3_err_ok", 32'(err), 0);

    pulse_start(); send(8'h01, 0); send(8'hAA, 0); send(8'hBB, 0);
    bif.in_valid = 1; bif.in_data = 8'hCC; abort = 1;
    @(negedge clk); chk("t4_rdy_abort", 32'(bif.in_ready), 0);
    tick(); abort = 0; bif.in_valid = 0;
    chk("t4_idle_busy", 32'(busy), 0); chk("t4_idle_rdy", 32'(bif.in_ready), 0);
    repeat (3) tick();
    pulse_start();
    sb.push_back({32'h0, 32'h44332211});
    send(8'h01, 0); send_word(32'h44332211, 0);
    wait_done();

    pulse_start(); send(8'h01, 0); send(8'h11, 0); send(8'h22, 0);
    #2 rst_n = 0;
    #1 chk_zero("t5");
    tick(); #2 rst_n = 1;
    tick(); pulse_start();
    sb.push_back({32'h0, 32'h0A0B0C0D});
    send(8'h01, 0); send_word(32'h0A0B0C0D, 0);
    wait_done();

    pulse_start(); send(8'h20, 0);
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      sb.push_back({32'(i * 4), w});
      if (i == 5 || i == 20) pulse_start();
      send_word(w, 0);
    end
    wait_done();
    repeat (5) tick();
    chk("t6_done_once", 32'(done_cnt - d0), 1);
    chk("t6_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
